// File: rtl/onehot_seq_ctrl.sv
// onehot_seq_ctrl: arbitrates two requesters for one shared onehot counter.
// A granted job loads a pattern into the counter and then rotates it a
// requested number of steps in a requested direction. Completion is signalled
// with a one-cycle done pulse. All outputs are registered (Moore style) and
// are decoded from the next-state values, so they change together with the
// state register.
module onehot_seq_ctrl #(
    parameter int N  = 6,
    parameter int CW = 4
) (
    input  logic          in_clk,
    input  logic          rst,
    input  logic          in_req_a,
    input  logic [N-1:0]  in_pat_a,
    input  logic          in_dir_a,
    input  logic [CW-1:0] in_cnt_a,
    input  logic          in_req_b,
    input  logic [N-1:0]  in_pat_b,
    input  logic          in_dir_b,
    input  logic [CW-1:0] in_cnt_b,
    output logic          ou_gnt_a,
    output logic          ou_gnt_b,
    output logic          ou_done_a,
    output logic          ou_done_b,
    output logic [1:0]    ou_sel,
    output logic [N-1:0]  ou_p,
    output logic          ou_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Counter select encodings
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_ROR  = 2'b01;
    localparam logic [1:0] SEL_ROL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    state_t        state_q, state_d;
    logic [N-1:0]  pat_q, pat_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] step_q, step_d;
    logic          owner_b_q, owner_b_d;   // 0 = A owns the job, 1 = B
    logic          last_b_q, last_b_d;     // 1 = B was served last

    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic          done_a_q, done_a_d;
    logic          done_b_q, done_b_d;
    logic [1:0]    sel_q, sel_d;
    logic [N-1:0]  p_q, p_d;
    logic          busy_q, busy_d;

    // Next-state logic: arbitration, job capture and step counting
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        owner_b_d = owner_b_q;
        last_b_d  = last_b_q;
        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that was not served last wins
                if (in_req_a && (!in_req_b || last_b_q)) begin
                    owner_b_d = 1'b0;
                    pat_d     = in_pat_a;
                    dir_d     = in_dir_a;
                    cnt_d     = in_cnt_a;
                    state_d   = ST_LOAD;
                end else if (in_req_b) begin
                    owner_b_d = 1'b1;
                    pat_d     = in_pat_b;
                    dir_d     = in_dir_b;
                    cnt_d     = in_cnt_b;
                    state_d   = ST_LOAD;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_LOAD: begin
                step_d = cnt_q;
                if (cnt_q != {CW{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_RUN: begin
                // The step counter holds the number of RUN cycles left,
                // including the current one
                step_d = step_q - CW'(1);
                if (step_q == CW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                last_b_d = owner_b_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it
    always_comb begin
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        sel_d    = SEL_HOLD;
        p_d      = {N{1'b0}};
        busy_d   = 1'b0;
        if (state_d != ST_IDLE) begin
            gnt_a_d = ~owner_b_d;
            gnt_b_d = owner_b_d;
            busy_d  = 1'b1;
            p_d     = pat_d;
        end else begin
            busy_d  = 1'b0;
        end
        case (state_d)
            ST_IDLE: begin
                sel_d = SEL_HOLD;
            end
            ST_LOAD: begin
                sel_d = SEL_LOAD;
            end
            ST_RUN: begin
                if (dir_d) begin
                    sel_d = SEL_ROR;
                end else begin
                    sel_d = SEL_ROL;
                end
            end
            ST_DONE: begin
                sel_d    = SEL_HOLD;
                done_a_d = ~owner_b_d;
                done_b_d = owner_b_d;
            end
            default: begin
                sel_d = SEL_HOLD;
            end
        endcase
    end

    // State, capture and output registers; reset leaves B as last served
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= {N{1'b0}};
            dir_q     <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            step_q    <= {CW{1'b0}};
            owner_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            sel_q     <= 2'b00;
            p_q       <= {N{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            owner_b_q <= owner_b_d;
            last_b_q  <= last_b_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            sel_q     <= sel_d;
            p_q       <= p_d;
            busy_q    <= busy_d;
        end
    end

    assign ou_gnt_a  = gnt_a_q;
    assign ou_gnt_b  = gnt_b_q;
    assign ou_done_a = done_a_q;
    assign ou_done_b = done_b_q;
    assign ou_sel    = sel_q;
    assign ou_p      = p_q;
    assign ou_busy   = busy_q;

endmodule

// File: doc/onehot_seq_ctrl.md
Name: onehot_seq_ctrl

Overview:
Sequencer and arbiter that shares one onehot_counter between two requesters (A and B).
A granted requester's job is "load pattern, then rotate it a given number of steps in a given direction".
The controller drives the counter's select and parallel-load inputs, then reports completion with a one-cycle done pulse.
It sits directly in front of the counter's in_sel/in_p inputs; its ou_sel/ou_p connect to them.

Parameters:
N, 6, pattern width; matches the counter width.
CW, 4, width of the step-count fields.

Ports:
in_clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
in_req_a  input  1  requester A job request; held high until ou_done_a
in_pat_a  input  N  A's load pattern
in_dir_a  input  1  A's direction: 0 = rotate left, 1 = rotate right
in_cnt_a  input  CW  A's number of rotate steps
in_req_b, in_pat_b, in_dir_b, in_cnt_b  input  1/N/1/CW  the same fields for requester B
ou_gnt_a  output  1  A owns the counter
ou_gnt_b  output  1  B owns the counter
ou_done_a  output  1  one-cycle pulse when A's job completes
ou_done_b  output  1  one-cycle pulse when B's job completes
ou_sel  output  2  to counter in_sel: 00 hold, 01 rotate right, 10 rotate left, 11 parallel load
ou_p  output  N  to counter in_p
ou_busy  output  1  high in any state other than IDLE

Behaviour:
- One clock (in_clk). rst is asynchronous and active-low. While rst=0:
  - state = IDLE
  - every output = 0
  - all capture registers = 0
  - last-served pointer = B, so A wins the first tie
- All outputs are registered and decoded from state only (Moore); there is no combinational path from the inputs.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Outputs: ou_sel=00, ou_p=0, both grants low.
  - At each edge, sample the request lines:
    - only one request high: grant that requester;
    - both high: grant the requester not in the last-served pointer;
    - none high: stay in IDLE.
  - On grant, capture the granted requester's pattern, dir and cnt into internal registers, set its ou_gnt, and go to LOAD.
- LOAD (exactly 1 cycle):
  - ou_sel=11, ou_p=captured pattern.
  - Next state: RUN if captured cnt != 0, else DONE.
- RUN:
  - ou_sel = 01 if captured dir=1, else 10. ou_p holds the captured pattern (ignored by the counter).
  - The internal step counter starts at the captured cnt and decrements each edge.
  - Go to DONE on the edge where the step counter reaches 1 → exactly cnt cycles in RUN.
- DONE (exactly 1 cycle):
  - ou_sel=00, the owner's ou_done=1, ou_gnt still high.
  - Next edge: go to IDLE, clear the grant, set last-served = owner.
- Timing: a job occupies exactly cnt+2 cycles after the granting edge. An immediate re-request still sees one IDLE cycle, so a granted job costs at least 3 cycles including that IDLE cycle.
- The requester's input fields are sampled only at the grant edge. Changes afterwards, including dropping req mid-job, are ignored and the job always completes.
- The non-granted requester waits with no timeout. With both requesters held high, grants alternate strictly: A, B, A, B...
- The pattern is passed through unchecked; a non-one-hot pattern is the requester's responsibility.
- cnt is unsigned. The maximum is 2^CW-1 steps; there is no modulo-N reduction of the step count.
- Both ou_done lines and both ou_gnt lines are mutually exclusive at all times.
- Reset asserted mid-job: IDLE immediately (asynchronous). No done pulse is issued for the aborted job.

Test Plan:
- Reset: hold rst=0 for 3 edges with both reqs high → all outputs 0, ou_busy=0. Release rst → A is granted at the first edge after release.
- A alone, pat=6'b000001, dir=1, cnt=3 → ou_sel sequence 11,01,01,01,00 with ou_p=000001 during LOAD. ou_done_a high on the 5th cycle; ou_gnt_a high for cycles 1-5; counter model ends at 001000.
- Both reqs held, A: cnt=1 dir=0; B: cnt=2 dir=1 → grants A, then B, then A. Each job is separated by one IDLE cycle; ou_sel for B's job is 11,01,01,00.
- B alone, cnt=0, pat=6'b100000 → ou_sel 11 then 00. ou_done_b on the 2nd cycle; ou_busy high for 2 cycles.
- A job with cnt=5: drop in_req_a and change in_pat_a during RUN → job still runs 5 RUN cycles with the original pattern, and ou_done_a pulses once.
- A job with cnt=7: assert rst=0 in the 3rd RUN cycle → outputs go to 0 without waiting for an edge, and there is no ou_done_a pulse. After release with only B requesting, B is granted.
